// File: rtl/fc_fold_accumulator.sv
// Folded FC back end: AND weight/input bitstreams, popcount, accumulate per window, bank per fold.
// Results are valid FOLD*2^INWD+1 cycles after start and are held in DONE until out_ready.
module fc_fold_accumulator #(
    parameter int DIM_IN    = 16,
    parameter int DIM_OUT_F = 4,
    parameter int FOLD      = 4,
    parameter int LOG_FOLD  = $clog2(FOLD),
    parameter int INWD      = 8,
    parameter int ACCWD     = INWD + $clog2(DIM_IN) + 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [DIM_IN-1:0]               in_temporal,
    input  logic [DIM_OUT_F*DIM_IN-1:0]     weight_temporal,
    output logic                            bsg_enable,
    output logic [LOG_FOLD-1:0]             mux_select,
    output logic                            busy,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [FOLD*DIM_OUT_F*ACCWD-1:0] result
);

    localparam int NRES = FOLD * DIM_OUT_F;
    localparam int PCWD = $clog2(DIM_IN) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [LOG_FOLD-1:0] LAST_FOLD = LOG_FOLD'(FOLD - 1);

    logic [1:0]          state_q, state_d;
    logic [INWD-1:0]     beat_q, beat_d;
    logic [LOG_FOLD-1:0] fold_q, fold_d;
    logic [ACCWD-1:0]    acc_q [DIM_OUT_F];
    logic [ACCWD-1:0]    acc_d [DIM_OUT_F];
    logic [ACCWD-1:0]    res_q [NRES];
    logic [ACCWD-1:0]    res_d [NRES];

    logic [PCWD-1:0]     pc    [DIM_OUT_F];
    logic [ACCWD-1:0]    sum   [DIM_OUT_F];
    logic                last_beat;

    // Generator output is combinational on its count, so this cycle's bits are consumed directly.
    always_comb begin
        for (int o = 0; o < DIM_OUT_F; o++) begin
            pc[o] = '0;
            for (int i = 0; i < DIM_IN; i++) begin
                pc[o] = pc[o] + PCWD'(weight_temporal[o*DIM_IN+i] & in_temporal[i]);
            end
            sum[o] = acc_q[o] + ACCWD'(pc[o]);
        end
    end

    assign last_beat = &beat_q;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        fold_d  = fold_q;
        for (int o = 0; o < DIM_OUT_F; o++) begin
            acc_d[o] = acc_q[o];
        end
        for (int k = 0; k < NRES; k++) begin
            res_d[k] = res_q[k];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    beat_d  = '0;
                    fold_d  = '0;
                    for (int o = 0; o < DIM_OUT_F; o++) begin
                        acc_d[o] = '0;
                    end
                end
            end
            S_RUN: begin
                beat_d = beat_q + INWD'(1);
                if (last_beat) begin
                    for (int k = 0; k < NRES; k++) begin
                        if (LOG_FOLD'(k / DIM_OUT_F) == fold_q) begin
                            res_d[k] = sum[k % DIM_OUT_F];
                        end
                    end
                    for (int o = 0; o < DIM_OUT_F; o++) begin
                        acc_d[o] = '0;
                    end
                    // FOLD is a power of two, so the last fold wraps back to 0 for the next run.
                    fold_d = fold_q + LOG_FOLD'(1);
                    if (fold_q == LAST_FOLD) begin
                        state_d = S_DONE;
                    end
                end else begin
                    for (int o = 0; o < DIM_OUT_F; o++) begin
                        acc_d[o] = sum[o];
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            fold_q  <= '0;
            for (int o = 0; o < DIM_OUT_F; o++) begin
                acc_q[o] <= '0;
            end
            for (int k = 0; k < NRES; k++) begin
                res_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            fold_q  <= fold_d;
            for (int o = 0; o < DIM_OUT_F; o++) begin
                acc_q[o] <= acc_d[o];
            end
            for (int k = 0; k < NRES; k++) begin
                res_q[k] <= res_d[k];
            end
        end
    end

    assign bsg_enable = (state_q == S_RUN);
    assign mux_select = bsg_enable ? fold_q : '0;
    assign busy       = (state_q != S_IDLE);
    assign out_valid  = (state_q == S_DONE);

    for (genvar k = 0; k < NRES; k++) begin : g_result
        assign result[k*ACCWD +: ACCWD] = res_q[k];
    end

endmodule

// File: tb/tb_fc_fold_accumulator.sv
// Bench for fc_fold_accumulator: scoreboarded full inferences with timing, backpressure and reset scenarios.
module tb_fc_fold_accumulator;

    localparam int DIM_IN    = 16;
    localparam int DIM_OUT_F = 4;
    localparam int FOLD      = 4;
    localparam int LOG_FOLD  = 2;
    localparam int INWD      = 8;
    localparam int ACCWD     = 13;
    localparam int W         = 256;
    localparam int NRES      = FOLD * DIM_OUT_F;
    localparam int RW        = NRES * ACCWD;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        start;
    logic [DIM_IN-1:0]           in_temporal;
    logic [DIM_OUT_F*DIM_IN-1:0] weight_temporal;
    logic                        bsg_enable;
    logic [LOG_FOLD-1:0]         mux_select;
    logic                        busy;
    logic                        out_valid;
    logic                        out_ready;
    logic [RW-1:0]               result;

    int n_tests = 0;
    int n_fail  = 0;
    logic [RW-1:0] exp_q[$];

    always #5 clk = ~clk;

    fc_fold_accumulator #(
        .DIM_IN(DIM_IN), .DIM_OUT_F(DIM_OUT_F), .FOLD(FOLD),
        .LOG_FOLD(LOG_FOLD), .INWD(INWD), .ACCWD(ACCWD)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_temporal(in_temporal), .weight_temporal(weight_temporal),
        .bsg_enable(bsg_enable), .mux_select(mux_select), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    // Drives one inference from the current negedge; modes: 0 all ones, 1 zero weights,
    // 2 lanes i<4*(f+1), 3 random. The expected bank vector is pushed when the run completes.
    task automatic drive_run(input int mode, input int repulse_at, input int rst_at,
                             output int en_cnt, output int en_err, output bit aborted);
        int unsigned acc [NRES];
        logic [RW-1:0] ev;
        logic [DIM_IN-1:0] iv;
        logic [DIM_OUT_F*DIM_IN-1:0] wv;
        int f;
        for (int k = 0; k < NRES; k++) acc[k] = 0;
        en_cnt  = 0;
        en_err  = 0;
        aborted = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < FOLD*W; c++) begin
            f = c / W;
            if (c == rst_at) begin
                rst = 1'b1;
                aborted = 1'b1;
                return;
            end
            if (bsg_enable === 1'b1) en_cnt++;
            if (bsg_enable !== 1'b1 || mux_select !== LOG_FOLD'(f) || out_valid !== 1'b0 || busy !== 1'b1)
                en_err++;
            start = (c == repulse_at);
            case (mode)
                0: begin iv = '1; wv = '1; end
                1: begin iv = '1; wv = '0; end
                2: begin
                    iv = '1;
                    for (int o = 0; o < DIM_OUT_F; o++)
                        for (int i = 0; i < DIM_IN; i++)
                            wv[o*DIM_IN+i] = (i < 4*(f+1));
                end
                default: begin iv = DIM_IN'($urandom()); wv = {$urandom(), $urandom()}; end
            endcase
            for (int o = 0; o < DIM_OUT_F; o++)
                acc[f*DIM_OUT_F+o] += $countones(wv[o*DIM_IN +: DIM_IN] & iv);
            in_temporal     = iv;
            weight_temporal = wv;
            @(negedge clk);
        end
        start = 1'b0;
        // Inputs are don't-care once the generator is disabled.
        in_temporal     = DIM_IN'($urandom());
        weight_temporal = {$urandom(), $urandom()};
        for (int k = 0; k < NRES; k++) ev[k*ACCWD +: ACCWD] = ACCWD'(acc[k]);
        exp_q.push_back(ev);
    endtask

    task automatic handshake(input bit with_start);
        out_ready = 1'b1;
        start     = with_start;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        in_temporal = '1; weight_temporal = '1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bsg_enable, mux_select, busy, out_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got en=%b sel=%0d busy=%b vld=%b, expected all 0",
                     bsg_enable, mux_select, busy, out_valid);
        end
        n_tests++;
        if (result !== '0) begin
            n_fail++;
            $display("FAIL reset_result: got %h expected 0", result);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_all_ones();
        int en_cnt, en_err, bad;
        bit ab;
        logic [RW-1:0] ev;
        drive_run(0, -1, -1, en_cnt, en_err, ab);
        n_tests++;
        if (en_cnt !== 1024) begin
            n_fail++;
            $display("FAIL all_ones_en_cycles: got %0d expected 1024", en_cnt);
        end
        n_tests++;
        if (en_err !== 0) begin
            n_fail++;
            $display("FAIL all_ones_run_timing: got %0d bad cycles expected 0", en_err);
        end
        n_tests++;
        if (out_valid !== 1'b1 || bsg_enable !== 1'b0 || mux_select !== '0) begin
            n_fail++;
            $display("FAIL all_ones_latency: got vld=%b en=%b sel=%0d expected vld=1 en=0 sel=0",
                     out_valid, bsg_enable, mux_select);
        end
        ev = exp_q.pop_front();
        n_tests++;
        if (result !== ev) begin
            n_fail++;
            $display("FAIL all_ones_result: got %h expected %h", result, ev);
        end
        bad = 0;
        for (int k = 0; k < NRES; k++) if (result[k*ACCWD +: ACCWD] !== 13'd4096) bad++;
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL all_ones_4096: got %0d entries differing, expected 0", bad);
        end
        handshake(1'b0);
        n_tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL all_ones_idle: got busy=%b vld=%b expected 0 0", busy, out_valid);
        end
    endtask

    task automatic test_zero_weights();
        int en_cnt, en_err;
        bit ab;
        logic [RW-1:0] ev;
        drive_run(1, -1, -1, en_cnt, en_err, ab);
        n_tests++;
        if (en_cnt !== 1024 || en_err !== 0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_timing: got en_cnt=%0d bad=%0d vld=%b expected 1024 0 1", en_cnt, en_err, out_valid);
        end
        ev = exp_q.pop_front();
        n_tests++;
        if (result !== ev || result !== '0) begin
            n_fail++;
            $display("FAIL zero_result: got %h expected %h", result, ev);
        end
        handshake(1'b0);
    endtask

    task automatic test_fold_lanes();
        int en_cnt, en_err;
        bit ab;
        logic [RW-1:0] ev;
        drive_run(2, -1, -1, en_cnt, en_err, ab);
        ev = exp_q.pop_front();
        n_tests++;
        if (result !== ev) begin
            n_fail++;
            $display("FAIL lanes_result: got %h expected %h", result, ev);
        end
        for (int f = 0; f < FOLD; f++) begin
            n_tests++;
            if (result[(f*DIM_OUT_F+1)*ACCWD +: ACCWD] !== ACCWD'(1024*(f+1))) begin
                n_fail++;
                $display("FAIL lanes_fold%0d: got %0d expected %0d", f,
                         result[(f*DIM_OUT_F+1)*ACCWD +: ACCWD], 1024*(f+1));
            end
        end
        handshake(1'b0);
    endtask

    task automatic test_backpressure();
        int en_cnt, en_err, stab_err;
        bit ab;
        logic [RW-1:0] ev;
        drive_run(3, -1, -1, en_cnt, en_err, ab);
        ev = exp_q.pop_front();
        stab_err = 0;
        for (int c = 0; c < 50; c++) begin
            if (out_valid !== 1'b1 || bsg_enable !== 1'b0 || result !== ev) stab_err++;
            @(negedge clk);
        end
        n_tests++;
        if (stab_err !== 0) begin
            n_fail++;
            $display("FAIL bp_hold: got %0d unstable cycles expected 0", stab_err);
        end
        n_tests++;
        if (result !== ev) begin
            n_fail++;
            $display("FAIL bp_result: got %h expected %h", result, ev);
        end
        handshake(1'b0);
        n_tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_idle: got busy=%b vld=%b expected 0 0", busy, out_valid);
        end
    endtask

    task automatic test_restart_ignored();
        int en_cnt, en_err;
        bit ab;
        logic [RW-1:0] ev;
        drive_run(3, W + 100, -1, en_cnt, en_err, ab);
        n_tests++;
        if (en_cnt !== 1024 || en_err !== 0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_timing: got en_cnt=%0d bad=%0d vld=%b expected 1024 0 1", en_cnt, en_err, out_valid);
        end
        ev = exp_q.pop_front();
        n_tests++;
        if (result !== ev) begin
            n_fail++;
            $display("FAIL restart_result: got %h expected %h", result, ev);
        end
        // start together with out_ready in DONE only completes the handshake.
        handshake(1'b1);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_start_idle: got busy=%b expected 0", busy);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || bsg_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL done_start_not_captured: got busy=%b en=%b expected 0 0", busy, bsg_enable);
        end
    endtask

    task automatic test_reset_midrun();
        int en_cnt, en_err, vld_seen;
        bit ab;
        logic [RW-1:0] ev;
        drive_run(0, -1, 2*W + 37, en_cnt, en_err, ab);
        #1;
        n_tests++;
        if (!ab || {bsg_enable, mux_select, busy, out_valid} !== 5'b0 || result !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset: got aborted=%b en=%b sel=%0d busy=%b vld=%b result=%h expected all 0",
                     ab, bsg_enable, mux_select, busy, out_valid, result);
        end
        vld_seen = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            if (out_valid !== 1'b0) vld_seen++;
            @(negedge clk);
        end
        n_tests++;
        if (vld_seen !== 0) begin
            n_fail++;
            $display("FAIL midrun_no_valid: got %0d valid cycles expected 0", vld_seen);
        end
        drive_run(0, -1, -1, en_cnt, en_err, ab);
        ev = exp_q.pop_front();
        n_tests++;
        if (en_err !== 0 || out_valid !== 1'b1 || result !== ev) begin
            n_fail++;
            $display("FAIL midrun_rerun: got bad=%0d vld=%b result=%h expected 0 1 %h", en_err, out_valid, result, ev);
        end
        handshake(1'b0);
    endtask

    task automatic test_back_to_back();
        int en_cnt, en_err;
        bit ab;
        logic [RW-1:0] ev;
        drive_run(3, -1, -1, en_cnt, en_err, ab);
        handshake(1'b0);
        drive_run(2, -1, -1, en_cnt, en_err, ab);
        ev = exp_q.pop_front();
        ev = exp_q.pop_front();
        n_tests++;
        if (en_err !== 0 || out_valid !== 1'b1 || result !== ev) begin
            n_fail++;
            $display("FAIL b2b_second: got bad=%0d vld=%b result=%h expected 0 1 %h", en_err, out_valid, result, ev);
        end
        handshake(1'b0);
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_zero_weights();
        test_fold_lanes();
        test_backpressure();
        test_restart_ignored();
        test_reset_midrun();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
